// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
// Module   : can_pkg
// Brief    : Shared CAN frame widths, frame struct and small helpers.
// Revision : 1.0
// ============================================================================
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_DLC_W-1:0]  dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_acc_filter.sv
`default_nettype none
// ============================================================================
// Module   : can_acc_filter
// Brief    : Combinational 11-bit code/mask acceptance compare.
// Revision : 1.0
// ============================================================================
module can_acc_filter
  import can_pkg::*;
(
  input  logic                rx_valid,
  input  logic [CAN_ID_W-1:0] rx_id,
  input  logic [CAN_ID_W-1:0] acc_code,
  input  logic [CAN_ID_W-1:0] acc_mask,
  output logic                accept
);

  // Mask bit 1 = compare this ID bit, 0 = don't care.
  assign accept = rx_valid && (((rx_id ^ acc_code) & acc_mask) == '0);

endmodule
`default_nettype wire

// File: rtl/can_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : can_rx_fifo
// Brief    : Filtered first-word-fall-through receive FIFO with drop tracking.
// Revision : 1.0
// ============================================================================
module can_rx_fifo
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CAN_ID_W-1:0]   rx_id,
  input  logic [CAN_DLC_W-1:0]  rx_dlc,
  input  logic [CAN_DATA_W-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic [CAN_ID_W-1:0]   acc_code,
  input  logic [CAN_ID_W-1:0]   acc_mask,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CAN_ID_W-1:0]   out_id,
  output logic [CAN_DLC_W-1:0]  out_dlc,
  output logic [CAN_DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  can_frame_t       mem_q [DEPTH];
  can_frame_t       mem_d [DEPTH];

  logic       accept;
  logic       pop;
  logic       push;
  logic       drop;
  can_frame_t rx_frame;
  can_frame_t head;

  can_acc_filter u_acc_filter (
    .rx_valid (rx_valid),
    .rx_id    (rx_id),
    .acc_code (acc_code),
    .acc_mask (acc_mask),
    .accept   (accept)
  );

  assign rx_frame = '{id: rx_id, dlc: rx_dlc, data: rx_data};

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the slot in the same cycle, so a full FIFO can still take a frame.
  assign pop  = !empty && out_ready;
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop && !flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = rx_frame;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Clear first so a same-cycle drop lands on a zeroed counter.
    if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc8(drop_cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign out_id    = head.id;
  assign out_dlc   = head.dlc;
  assign out_data  = head.data;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_rx_fifo
// Brief    : Directed plus random bench for can_rx_fifo against a queue model.
// Revision : 1.0
// ============================================================================
module tb_can_rx_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [10:0]      rx_id;
  logic [3:0]       rx_dlc;
  logic [63:0]      rx_data;
  logic             rx_valid;
  logic [10:0]      acc_code;
  logic [10:0]      acc_mask;
  logic             flush;
  logic             ovf_clr;
  logic             out_valid;
  logic             out_ready;
  logic [10:0]      out_id;
  logic [3:0]       out_dlc;
  logic [63:0]      out_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [7:0]       drop_cnt;

  can_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rx_id(rx_id), .rx_dlc(rx_dlc), .rx_data(rx_data),
    .rx_valid(rx_valid), .acc_code(acc_code), .acc_mask(acc_mask),
    .flush(flush), .ovf_clr(ovf_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_id(out_id), .out_dlc(out_dlc),
    .out_data(out_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frm_t;

  frm_t mq[$];
  bit   m_ovf;
  int   m_drop;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    frm_t h;
    h = '{id: 11'd0, dlc: 4'd0, data: 64'd0};
    if (mq.size() > 0) h = mq[0];
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count",     64'(count),     64'(mq.size()));
    chk("full",      64'(full),      64'(mq.size() == DEPTH));
    chk("empty",     64'(empty),     64'(mq.size() == 0));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    chk("out_id",    64'(out_id),    64'(h.id));
    chk("out_dlc",   64'(out_dlc),   64'(h.dlc));
    chk("out_data",  out_data,       h.data);
  endtask

  // Reference behaviour of one clock edge, using the inputs held across it.
  task automatic model_edge();
    bit acc, pp, room, dropped;
    acc     = rx_valid && (((rx_id ^ acc_code) & acc_mask) == 11'd0);
    dropped = 1'b0;
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    if (flush) begin
      mq.delete();
    end else begin
      pp   = out_ready && (mq.size() > 0);
      room = mq.size() < DEPTH;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        if (room || pp) mq.push_back('{id: rx_id, dlc: rx_dlc, data: rx_data});
        else dropped = 1'b1;
      end
    end
    if (ovf_clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic tick();
    if (chk_en) check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    rx_id    = id;
    rx_dlc   = dlc;
    rx_data  = data;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    rst = 1'b1; rx_id = '0; rx_dlc = '0; rx_data = '0; rx_valid = 1'b0;
    acc_code = '0; acc_mask = '0; flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);

    // Pass-through with zero bubble
    out_ready = 1'b1;
    send(11'h123, 4'd8, 64'h0102030405060708);
    chk("pt_valid", 64'(out_valid), 64'd1);
    chk("pt_id",    64'(out_id),    64'h123);
    chk("pt_data",  out_data,       64'h0102030405060708);
    tick();
    chk("pt_empty", 64'(empty), 64'd1);

    // Acceptance filter
    out_ready = 1'b0;
    acc_code  = 11'h120;
    acc_mask  = 11'h7F0;
    send(11'h12A, 4'd2, 64'hAA);
    send(11'h13A, 4'd3, 64'hBB);
    chk("flt_count", 64'(count),  64'd1);
    chk("flt_id",    64'(out_id), 64'h12A);
    chk("flt_ovf",   64'(overflow), 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;

    // Fill and overflow
    acc_mask = '0;
    for (int i = 1; i <= 6; i++) send(11'(i), 4'(i + 8), {32'(i), 32'hDEAD0000 + 32'(i)});
    chk("ovf_full",  64'(full),     64'd1);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_drops", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_id", 64'(out_id), 64'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Push into a full FIFO with a simultaneous pop
    for (int i = 1; i <= 4; i++) send(11'(i), 4'd1, 64'(i));
    out_ready = 1'b1;
    send(11'd5, 4'd1, 64'd5);
    chk("pp_count", 64'(count),    64'd4);
    chk("pp_drops", 64'(drop_cnt), 64'd0);
    for (int i = 2; i <= 5; i++) begin
      chk("pp_order", 64'(out_id), 64'(i));
      tick();
    end
    out_ready = 1'b0;

    // Flush, overflow clear and reset
    for (int i = 1; i <= 5; i++) send(11'(i), 4'd2, 64'(i * 3));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    flush = 1'b1;
    send(11'h7, 4'd1, 64'h7);
    flush = 1'b0;
    chk("fl_count", 64'(count),    64'd0);
    chk("fl_drops", 64'(drop_cnt), 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("clr_ovf",   64'(overflow), 64'd0);
    chk("clr_drops", 64'(drop_cnt), 64'd0);
    send(11'h21, 4'd4, 64'h1111); send(11'h22, 4'd4, 64'h2222);
    chk("rf_count", 64'(count), 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_empty", 64'(empty),  64'd1);
    chk("rst2_data",  out_data,    64'd0);

    // Clear racing a drop, then saturation
    for (int i = 0; i < 6; i++) send(11'(i), 4'd0, 64'(i));
    ovf_clr = 1'b1;
    send(11'h55, 4'd0, 64'h55);
    ovf_clr = 1'b0;
    chk("race_drops", 64'(drop_cnt), 64'd1);
    chk("race_ovf",   64'(overflow), 64'd1);
    for (int i = 0; i < 300; i++) send(11'($urandom), 4'($urandom), {$urandom, $urandom});
    chk("sat_drops", 64'(drop_cnt), 64'd255);
    chk("sat_ovf",   64'(overflow), 64'd1);

    // Random traffic
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        rdy_pct  = $urandom_range(0, 100);
        acc_code = 11'($urandom);
        case ($urandom_range(0, 2))
          0:       acc_mask = '0;
          1:       acc_mask = 11'($urandom) & 11'h00F;
          default: acc_mask = 11'($urandom);
        endcase
      end
      rx_valid  = ($urandom_range(0, 99) < 60);
      rx_id     = 11'($urandom);
      rx_dlc    = 4'($urandom);
      rx_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      flush     = ($urandom_range(0, 99) < 2);
      ovf_clr   = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 999) < 5);
      tick();
    end
    rx_valid = 1'b0; flush = 1'b0; ovf_clr = 1'b0; rst = 1'b0; out_ready = 1'b0;
    tick();
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
